row_clear_controller: RTL and testbench



---
 rtl/board_pkg.sv | 25 ++
 rtl/row_clear_controller_if.sv | 37 +++
 rtl/line_score_lut.sv | 18 +
 rtl/row_clear_controller.sv | 152 +++++++++++++++
 tb/tb_row_clear_controller.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/board_pkg.sv
// Shared board geometry, row types and the row-clear controller state encoding.
package board_pkg;
    localparam int BOARD_WIDTH  = 10;
    localparam int BOARD_HEIGHT = 20;
    localparam int ROW_W        = 7;
    localparam int CNT_W        = 5;
    localparam int SCORE_W      = 20;
    localparam int PTS_W        = 11;

    typedef logic [BOARD_WIDTH-1:0] row_t;
    typedef logic [ROW_W-1:0]       row_idx_t;
    // One extra bit so a pointer can step past row 0 to -1 unambiguously.
    typedef logic [ROW_W:0]         row_ptr_t;

    localparam row_t FULL_ROW = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_EV,
        ST_WR,
        ST_FILL,
        ST_DONE
    } clr_state_t;
endpackage

// File: rtl/row_clear_controller_if.sv
// Request/status and board-memory signals of the row-clear controller.
// Score exists only when ROW_CLEAR_SCORE_EN is defined.
interface row_clear_controller_if;
    import board_pkg::*;

    logic                 Start;
    logic                 Busy;
    logic                 Done;
    row_idx_t             Mem_addr;
    logic                 Mem_we;
    row_t                 Mem_wdata;
    row_t                 Mem_rdata;
    logic                 Clear_row;
    row_idx_t             Row_to_clear;
    logic [CNT_W-1:0]     Num_rows_to_clear;
`ifdef ROW_CLEAR_SCORE_EN
    logic [SCORE_W-1:0]   Score;
`endif

    modport slave (
        input  Start, Mem_rdata,
        output Busy, Done, Mem_addr, Mem_we, Mem_wdata,
               Clear_row, Row_to_clear, Num_rows_to_clear
`ifdef ROW_CLEAR_SCORE_EN
        , Score
`endif
    );

    modport master (
        output Start, Mem_rdata,
        input  Busy, Done, Mem_addr, Mem_we, Mem_wdata,
               Clear_row, Row_to_clear, Num_rows_to_clear
`ifdef ROW_CLEAR_SCORE_EN
        , Score
`endif
    );
endinterface

// File: rtl/line_score_lut.sv
// Points awarded for the number of rows cleared in one scan (ROW_CLEAR_SCORE_EN builds only).
module line_score_lut
    import board_pkg::*;
(
    input  logic [CNT_W-1:0] count,
    output logic [PTS_W-1:0] points
);
    always_comb begin
        points = '0;
        case (count)
            5'd0:    points = PTS_W'(0);
            5'd1:    points = PTS_W'(40);
            5'd2:    points = PTS_W'(100);
            5'd3:    points = PTS_W'(300);
            default: points = PTS_W'(1200);
        endcase
    end
endmodule

// File: rtl/row_clear_controller.sv
// Bottom-up scan of the board memory that drops full rows and compacts the rest in place.
// Optional saturating score accumulator when ROW_CLEAR_SCORE_EN is defined.
//
// state | meaning
// IDLE  | waiting for Start
// RD    | address row rd for reading
// EV    | row rd data available; classify full / keep / move
// WR    | write the kept row to wr
// FILL  | write empty rows from wr up to row 0
// DONE  | one-cycle completion pulse, Busy low
module row_clear_controller
    import board_pkg::*;
(
    input  logic Clk,
    input  logic Reset,
    row_clear_controller_if.slave bus
);
    clr_state_t       state;
    row_ptr_t         rd, wr;
    logic [CNT_W-1:0] count;
    logic             busy_q, done_q, we_q, clr_q;
    row_idx_t         addr_q, rtc_q;
    row_t             wdata_q;

    logic     row_full, move_row, advance;
    row_ptr_t rd_dec, wr_dec, wr_next;

    always_comb begin
        row_full = (bus.Mem_rdata == FULL_ROW);
        rd_dec   = rd - row_ptr_t'(1);
        wr_dec   = wr - row_ptr_t'(1);
        move_row = (state == ST_EV) && !row_full && (wr != rd);
        advance  = ((state == ST_EV) && !move_row) || (state == ST_WR);
        wr_next  = wr;
        if ((state == ST_WR) || ((state == ST_EV) && !row_full))
            wr_next = wr_dec;
    end

`ifdef ROW_CLEAR_SCORE_EN
    logic [SCORE_W-1:0] score_q;
    logic [PTS_W-1:0]   points;
    logic [SCORE_W:0]   score_sum;

    line_score_lut u_lut (.count(count), .points(points));

    assign score_sum = {1'b0, score_q} + (SCORE_W+1)'(points);
    assign bus.Score = score_q;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= ST_IDLE;
            rd      <= row_ptr_t'(BOARD_HEIGHT-1);
            wr      <= row_ptr_t'(BOARD_HEIGHT-1);
            count   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            we_q    <= 1'b0;
            clr_q   <= 1'b0;
            addr_q  <= '0;
            rtc_q   <= '0;
            wdata_q <= '0;
`ifdef ROW_CLEAR_SCORE_EN
            score_q <= '0;
`endif
        end else begin
            clr_q  <= 1'b0;
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.Start) begin
                        state  <= ST_RD;
                        rd     <= row_ptr_t'(BOARD_HEIGHT-1);
                        wr     <= row_ptr_t'(BOARD_HEIGHT-1);
                        count  <= '0;
                        addr_q <= row_idx_t'(BOARD_HEIGHT-1);
                        we_q   <= 1'b0;
                        busy_q <= 1'b1;
                    end
                end
                ST_RD: begin
                    state <= ST_EV;
                    we_q  <= 1'b0;
                end
                ST_EV: begin
                    if (row_full) begin
                        clr_q <= 1'b1;
                        rtc_q <= rd[ROW_W-1:0];
                        count <= count + CNT_W'(1);
                    end
                    if (move_row) begin
                        state   <= ST_WR;
                        addr_q  <= wr[ROW_W-1:0];
                        we_q    <= 1'b1;
                        wdata_q <= bus.Mem_rdata;
                    end
                end
                ST_WR: ;
                ST_FILL: begin
                    wr <= wr_dec;
                    if (wr_dec[ROW_W]) begin
                        state  <= ST_DONE;
                        we_q   <= 1'b0;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        addr_q <= wr_dec[ROW_W-1:0];
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
`ifdef ROW_CLEAR_SCORE_EN
                    score_q <= score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
`endif
                end
                default: state <= ST_IDLE;
            endcase

            // Common end-of-row step shared by EV (no move) and WR.
            if (advance) begin
                wr <= wr_next;
                if (rd == '0) begin
                    if (wr_next[ROW_W]) begin
                        state  <= ST_DONE;
                        we_q   <= 1'b0;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        state   <= ST_FILL;
                        addr_q  <= wr_next[ROW_W-1:0];
                        we_q    <= 1'b1;
                        wdata_q <= '0;
                    end
                end else begin
                    rd     <= rd_dec;
                    addr_q <= rd_dec[ROW_W-1:0];
                    we_q   <= 1'b0;
                    state  <= ST_RD;
                end
            end
        end
    end

    assign bus.Busy              = busy_q;
    assign bus.Done              = done_q;
    assign bus.Mem_addr          = addr_q;
    assign bus.Mem_we            = we_q;
    assign bus.Mem_wdata         = wdata_q;
    assign bus.Clear_row         = clr_q;
    assign bus.Row_to_clear      = rtc_q;
    assign bus.Num_rows_to_clear = count;
endmodule

// File: tb/tb_row_clear_controller.sv
// Directed bench for row_clear_controller with a board-memory model and a cleared-row scoreboard.
module tb_row_clear_controller;
    import board_pkg::*;

    logic Clk = 1'b0;
    logic Reset;
    logic load;
    always #5 Clk = ~Clk;

    row_clear_controller_if bus();
    row_clear_controller dut (.Clk(Clk), .Reset(Reset), .bus(bus));

    row_t mem [BOARD_HEIGHT];
    row_t img [BOARD_HEIGHT];

    always @(posedge Clk) begin
        if (load) begin
            for (int i = 0; i < BOARD_HEIGHT; i++) mem[i] <= img[i];
        end else if (bus.Mem_we) begin
            mem[bus.Mem_addr] <= bus.Mem_wdata;
        end
        bus.Mem_rdata <= mem[bus.Mem_addr];
    end

    int checks = 0, failures = 0, wr_cnt = 0, done_cnt = 0;
    int exp_q[$];
`ifdef ROW_CLEAR_SCORE_EN
    int exp_score = 0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge Clk) begin
        if (!Reset) begin
            if (bus.Mem_we) wr_cnt++;
            if (bus.Done) done_cnt++;
            if (bus.Clear_row) begin
                if (exp_q.size() == 0) check("clear_row_unexpected", 32'd1, 32'd0);
                else check("row_to_clear", 32'(bus.Row_to_clear), 32'(exp_q.pop_front()));
            end
        end
    end

    // Reference compaction: keep non-full rows in order, packed toward the bottom.
    task automatic model(output row_t out [BOARD_HEIGHT], output int cnt, output int nwr, output int lat);
        int k, first_full, moves;
        k = BOARD_HEIGHT - 1; cnt = 0; moves = 0; first_full = -1;
        for (int r = BOARD_HEIGHT - 1; r >= 0; r--) begin
            if (img[r] == FULL_ROW) begin
                exp_q.push_back(r);
                cnt++;
                if (first_full < 0) first_full = r;
            end else begin
                out[k] = img[r];
                k--;
                if (first_full >= 0) moves++;
            end
        end
        for (int j = k; j >= 0; j--) out[j] = '0;
        nwr = moves + cnt;
        lat = 2 * BOARD_HEIGHT + moves + cnt + 1;
    endtask

    task automatic load_board();
        @(negedge Clk) load = 1'b1;
        @(negedge Clk) load = 1'b0;
    endtask

    task automatic run_scan(input string name, input bit poke);
        row_t exp_mem [BOARD_HEIGHT];
        int cnt, nwr, lat, cyc, w0, d0;
        bit seen;
        load_board();
        model(exp_mem, cnt, nwr, lat);
        w0 = wr_cnt; d0 = done_cnt;
        @(negedge Clk) bus.Start = 1'b1;
        @(negedge Clk) bus.Start = 1'b0;
        check({name, "_busy"}, 32'(bus.Busy), 32'd1);
        cyc = 1; seen = 1'b0;
        while (!seen && cyc < 400) begin
            if (bus.Done) seen = 1'b1;
            else begin
                if (poke && cyc == 10) bus.Start = 1'b1;
                if (poke && cyc == 11) bus.Start = 1'b0;
                @(negedge Clk);
                cyc++;
            end
        end
        check({name, "_done_seen"}, 32'(seen), 32'd1);
        check({name, "_latency"}, 32'(cyc), 32'(lat));
        check({name, "_busy_in_done"}, 32'(bus.Busy), 32'd0);
        if (poke) bus.Start = 1'b1;
        @(negedge Clk) bus.Start = 1'b0;
        repeat (50) @(negedge Clk);
        check({name, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
        check({name, "_busy_after"}, 32'(bus.Busy), 32'd0);
        check({name, "_writes"}, 32'(wr_cnt - w0), 32'(nwr));
        check({name, "_missing_clears"}, 32'(exp_q.size()), 32'd0);
        check({name, "_count"}, 32'(bus.Num_rows_to_clear), 32'(cnt));
        for (int r = 0; r < BOARD_HEIGHT; r++)
            check($sformatf("%s_row%0d", name, r), 32'(mem[r]), 32'(exp_mem[r]));
`ifdef ROW_CLEAR_SCORE_EN
        case (cnt)
            0: ;
            1: exp_score += 40;
            2: exp_score += 100;
            3: exp_score += 300;
            default: exp_score += 1200;
        endcase
        if (exp_score > 32'hFFFFF) exp_score = 32'hFFFFF;
        check({name, "_score"}, 32'(bus.Score), 32'(exp_score));
`endif
        exp_q.delete();
    endtask

    initial begin
        int n;
        bus.Start = 1'b0;
        load = 1'b0;
        Reset = 1'b1;
        for (int r = 0; r < BOARD_HEIGHT; r++) img[r] = '0;
        repeat (3) @(negedge Clk);
        check("rst_busy", 32'(bus.Busy), 32'd0);
        check("rst_done", 32'(bus.Done), 32'd0);
        check("rst_we", 32'(bus.Mem_we), 32'd0);
        check("rst_addr", 32'(bus.Mem_addr), 32'd0);
        check("rst_clear", 32'(bus.Clear_row), 32'd0);
        check("rst_count", 32'(bus.Num_rows_to_clear), 32'd0);
        Reset = 1'b0;

        run_scan("empty", 1'b0);

        for (int r = 0; r < BOARD_HEIGHT; r++) img[r] = '0;
        img[19] = FULL_ROW; img[18] = 10'h3F0;
        run_scan("one_full", 1'b0);

        for (int r = 0; r < BOARD_HEIGHT; r++) img[r] = row_t'(r * 37 + 2);
        img[16] = FULL_ROW; img[17] = FULL_ROW; img[18] = FULL_ROW; img[19] = FULL_ROW;
        img[15] = 10'h001;
        run_scan("four_full", 1'b0);

        for (int r = 0; r < BOARD_HEIGHT; r++) img[r] = row_t'(r + 1);
        img[19] = FULL_ROW; img[18] = 10'h155; img[17] = FULL_ROW; img[16] = 10'h0AA;
        run_scan("gap_full_poke", 1'b1);

        for (int r = 0; r < BOARD_HEIGHT; r++)
            img[r] = ($urandom_range(0, 3) == 0) ? FULL_ROW : row_t'($urandom_range(0, 1022));
        run_scan("random", 1'b0);

        // Abort during FILL: rows 0..15 are non-zero so only FILL writes zeros.
        for (int r = 0; r < BOARD_HEIGHT; r++) img[r] = row_t'(r + 1);
        img[16] = FULL_ROW; img[17] = FULL_ROW; img[18] = FULL_ROW; img[19] = FULL_ROW;
        load_board();
        begin
            row_t dm [BOARD_HEIGHT];
            int c, w, l;
            model(dm, c, w, l);
        end
        @(negedge Clk) bus.Start = 1'b1;
        @(negedge Clk) bus.Start = 1'b0;
        n = 0;
        while (!(bus.Mem_we && bus.Mem_wdata == '0) && n < 200) begin
            @(negedge Clk);
            n++;
        end
        check("fill_reached", 32'(n < 200), 32'd1);
        check("fill_clears_reported", 32'(exp_q.size()), 32'd0);
        Reset = 1'b1;
        @(negedge Clk);
        check("midrst_busy", 32'(bus.Busy), 32'd0);
        check("midrst_we", 32'(bus.Mem_we), 32'd0);
        check("midrst_addr", 32'(bus.Mem_addr), 32'd0);
        check("midrst_done", 32'(bus.Done), 32'd0);
        check("midrst_count", 32'(bus.Num_rows_to_clear), 32'd0);
        check("midrst_rtc", 32'(bus.Row_to_clear), 32'd0);
        Reset = 1'b0;
        exp_q.delete();
`ifdef ROW_CLEAR_SCORE_EN
        exp_score = 0;
`endif

        for (int r = 0; r < BOARD_HEIGHT; r++) img[r] = row_t'(r * 5 + 3);
        img[19] = FULL_ROW; img[10] = FULL_ROW; img[0] = FULL_ROW;
        run_scan("after_reset", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
